// File: rtl/trp_ctrl_if.sv
// Row stream interface (valid/ready/data) between the tensor loader, trp_ctrl and the consumer.
// Latency: none, wires only.
// Backpressure: a row transfers on a cycle with vld & rdy; the master holds vld/dat until then.
// Ports: vld (row valid), rdy (row ready), dat (DW-bit row). Modports: master drives vld/dat, slave drives rdy.
interface trp_ctrl_if #(
    parameter int DW = 512
);
    logic          vld;
    logic          rdy;
    logic [DW-1:0] dat;

    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/trp_ctrl.sv
// Transpose-buffer sequencer: loads BUFFD rows into trp_fifo, then drains the transposed tile.
// Latency: 1 INIT cycle, BUFFD write cycles, then 1 row/cycle out after a 2-cycle read pipeline fill.
// Backpressure: in_rdy only in FILL; drain reads are throttled so a 2-entry skid absorbs out_rdy stalls.
// Ports: i_clk, i_reset_n (sync, active low), i_start/i_mode_in command, o_busy/o_done/o_err_mode status,
//        s_in (input row stream), m_out (output row stream), o_ff_mode/o_ffinit/o_ffwreq/o_ffwdata/o_ffrreq
//        to the buffer, i_ffrdata/i_ffrvld from the buffer.
// Optional macro TRP_CTRL_ABORT_EN adds i_abort: drops the current tile and reinitialises the buffer.
module trp_ctrl #(
    parameter int BUFFD = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode_in,
`ifdef TRP_CTRL_ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_mode,
    trp_ctrl_if.slave         s_in,
    trp_ctrl_if.master        m_out,
    output logic [1:0]        o_ff_mode,
    output logic              o_ffinit,
    output logic              o_ffwreq,
    output logic [BUFFD*8-1:0] o_ffwdata,
    output logic              o_ffrreq,
    input  logic [BUFFD*8-1:0] i_ffrdata,
    input  logic              i_ffrvld
);
    localparam int DW  = BUFFD * 8;
    localparam int WCW = $clog2(BUFFD);
    localparam int RLW = WCW + 1;
    localparam logic [WCW-1:0] WR_LAST = WCW'(BUFFD - 1);
    localparam logic [RLW-1:0] RD_8    = RLW'(BUFFD);
    localparam logic [RLW-1:0] RD_32   = RLW'(BUFFD / 4);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_FILL, ST_DRAIN} state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_err_mode;
    logic [1:0]      r_ff_mode;
    logic            r_ffinit;
    logic [WCW-1:0]  r_wr_cnt;
    logic [RLW-1:0]  r_rd_left;
    logic            r_inflight;
    logic [1:0]      r_occ;
    logic            r_wptr;
    logic            r_rptr;
    logic [DW-1:0]   r_skid [2];

    logic            w_in_rdy;
    logic            w_wr_hs;
    logic            w_out_vld;
    logic            w_pop;
    logic            w_push;
    logic [2:0]      w_pending;
    logic            w_rd_req;
    logic [1:0]      w_occ_after_pop;
    logic            w_drain_done;
    logic            w_mode_legal;
    logic            w_abort;

`ifdef TRP_CTRL_ABORT_EN
    assign w_abort = i_abort & (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_in_rdy  = (r_state == ST_FILL);
    assign w_wr_hs   = s_in.vld & w_in_rdy;
    assign w_out_vld = (r_occ != 2'd0);
    assign w_pop     = w_out_vld & m_out.rdy;
    // Only a row that answers our own request from last cycle is kept; this drops
    // stale returns after reset or abort, when r_inflight has been cleared.
    assign w_push    = i_ffrvld & r_inflight;

    // Rows already owed to the skid (held + in flight) once this cycle's pop retires.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_req  = (r_state == ST_DRAIN) && (r_rd_left != '0) && (w_pending < 3'd2);

    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    assign w_drain_done    = (r_state == ST_DRAIN) && (r_rd_left == '0) && !r_inflight &&
                             (w_occ_after_pop == 2'd0);
    assign w_mode_legal    = (i_mode_in == 2'b01) || (i_mode_in == 2'b10);

    assign s_in.rdy   = w_in_rdy;
    assign o_ffwreq   = w_wr_hs;
    assign o_ffwdata  = s_in.dat;
    assign o_ffrreq   = w_rd_req;
    assign m_out.vld  = w_out_vld;
    assign m_out.dat  = r_skid[r_rptr];
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err_mode = r_err_mode;
    assign o_ff_mode  = r_ff_mode;
    assign o_ffinit   = r_ffinit;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_mode <= 1'b0;
            r_ff_mode  <= 2'b01;
            r_ffinit   <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_left  <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err_mode <= 1'b0;
            r_ffinit   <= 1'b0;
            r_inflight <= w_rd_req;

            if (w_rd_req) r_rd_left <= r_rd_left - 1'b1;
            if (w_wr_hs)  r_wr_cnt  <= r_wr_cnt + 1'b1;

            if (w_push) begin
                r_skid[r_wptr] <= i_ffrdata;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_mode_legal) begin
                            r_ff_mode <= i_mode_in;
                            r_ffinit  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= ST_INIT;
                        end else begin
                            r_err_mode <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    r_wr_cnt <= '0;
                    r_state  <= ST_FILL;
                end
                ST_FILL: begin
                    if (w_wr_hs && (r_wr_cnt == WR_LAST)) begin
                        r_rd_left <= (r_ff_mode == 2'b10) ? RD_32 : RD_8;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Abort overrides everything above; ffinit re-arms the buffer counters.
            if (w_abort) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_ffinit   <= 1'b1;
                r_rd_left  <= '0;
                r_inflight <= 1'b0;
                r_occ      <= 2'd0;
                r_wptr     <= 1'b0;
                r_rptr     <= 1'b0;
                r_wr_cnt   <= '0;
            end
        end
    end
endmodule
